// File: rtl/txarbiter.sv
// txarbiter: round-robin arbiter feeding one shared serial word transmitter.
// Define TXARB_OVERRUN_EN to add sticky per-requester overrun flags (o_overrun).
module txarbiter #(
  parameter int NREQ = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [NREQ-1:0]     i_stb,
  input  logic [32*NREQ-1:0]  i_data,
  output logic [NREQ-1:0]     o_busy,
  output logic                o_tx_stb,
  output logic [31:0]         o_tx_data,
  input  logic                i_tx_busy,
  output logic [NREQ-1:0]     o_grant
`ifdef TXARB_OVERRUN_EN
  ,
  output logic [NREQ-1:0]     o_overrun
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   slot_q [NREQ];
  logic [IW-1:0] last_q;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic          pick;
  logic [NREQ-1:0] grant_d;

  // First full slot after the last winner, wrapping around
  always_comb begin
    win   = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!found && o_busy[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    grant_d      = '0;
    grant_d[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !i_tx_busy) begin
          pick    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (!i_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx_stb = (state_q == SEND);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      o_busy    <= '0;
      o_tx_data <= '0;
      o_grant   <= '0;
      last_q    <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      // last_q names the winner throughout SEND, so it selects the slot to free
      for (int i = 0; i < NREQ; i++) begin
        if (state_q == SEND && last_q == IW'(i)) begin
          o_busy[i] <= 1'b0;
        end else if (i_stb[i] && !o_busy[i]) begin
          o_busy[i] <= 1'b1;
        end
      end
      if (pick) begin
        last_q    <= win;
        o_tx_data <= slot_q[win];
        o_grant   <= grant_d;
      end else if (state_q == WAIT && !i_tx_busy) begin
        o_grant <= '0;
      end
    end
  end

  // Slot payload needs no reset: o_busy alone says whether it is valid
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (i_stb[i] && !o_busy[i]) slot_q[i] <= i_data[32*i +: 32];
    end
  end

`ifdef TXARB_OVERRUN_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) o_overrun <= '0;
    else            o_overrun <= o_overrun | (i_stb & o_busy);
  end
`endif

endmodule

// File: tb/tb_txarbiter.sv
// tb_txarbiter: directed scoreboard bench for txarbiter with a
// 10-cycle transmitter model.
module tb_txarbiter;

  localparam int NREQ  = 4;
  localparam int TXLEN = 10;

  logic              clk;
  logic              i_reset_n;
  logic [NREQ-1:0]   i_stb;
  logic [32*NREQ-1:0] i_data;
  logic [NREQ-1:0]   o_busy;
  logic              o_tx_stb;
  logic [31:0]       o_tx_data;
  logic              tx_busy;
  logic [NREQ-1:0]   o_grant;
`ifdef TXARB_OVERRUN_EN
  logic [NREQ-1:0]   o_overrun;
`endif

  txarbiter #(.NREQ(NREQ)) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_stb     (i_stb),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_tx_stb  (o_tx_stb),
    .o_tx_data (o_tx_data),
    .i_tx_busy (tx_busy),
    .o_grant   (o_grant)
`ifdef TXARB_OVERRUN_EN
    ,
    .o_overrun (o_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_stb = -1;
  int   tx_cnt   = 0;
  logic tx_force = 1'b0;
  logic rl_arm   = 1'b0;
  logic rl_now   = 1'b0;
  logic rl_clear = 1'b0;
  localparam logic [31:0] RL_WORD = 32'h2222_0002;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    q.push_back(e);
  endtask

  // One clock: sample after the edge, run monitor and transmitter model
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rl_clear) begin
      i_stb[2] = 1'b0;
      rl_clear = 1'b0;
    end
    if (rl_now) begin
      i_stb[2]        = 1'b1;
      i_data[95:64]   = RL_WORD;
      rl_now          = 1'b0;
      rl_clear        = 1'b1;
    end
    if (o_tx_stb) begin
      chk("stb_tx_busy_low", {63'd0, tx_busy}, 64'd0);
      if (last_stb >= 0) chk("stb_spacing", {63'd0, (cyc - last_stb) >= 3}, 64'd1);
      last_stb = cyc;
      n_chk++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_stb: observed data %0h expected no strobe", o_tx_data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tx_grant", {60'd0, o_grant}, {60'd0, e.g});
        chk("tx_data", {32'd0, o_tx_data}, {32'd0, e.d});
      end
      if (rl_arm && o_grant[2]) begin
        rl_now = 1'b1;
        rl_arm = 1'b0;
      end
    end
    if (tx_cnt > 0) tx_cnt--;
    if (o_tx_stb) tx_cnt = TXLEN;
    tx_busy = tx_force || (tx_cnt != 0);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) step();
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  task automatic tx_idle();
    for (int i = 0; i < 60 && tx_busy; i++) step();
    step();
    chk("tx_idle", {63'd0, tx_busy}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    i_reset_n = 1'b0;
    step();
    step();
    chk({tag, "_busy"}, {60'd0, o_busy}, 64'd0);
    chk({tag, "_grant"}, {60'd0, o_grant}, 64'd0);
    chk({tag, "_stb"}, {63'd0, o_tx_stb}, 64'd0);
    chk({tag, "_data"}, {32'd0, o_tx_data}, 64'd0);
`ifdef TXARB_OVERRUN_EN
    chk({tag, "_ovr"}, {60'd0, o_overrun}, 64'd0);
`endif
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_stb     = '0;
    i_data    = '0;
    tx_busy   = 1'b0;

    do_reset("rst0");

    // Single word: busy next cycle, strobe one cycle later
    i_data[31:0] = 32'hDEAD_BEEF;
    i_stb        = 4'b0001;
    push(4'b0001, 32'hDEAD_BEEF);
    step();
    i_stb = '0;
    chk("t1_busy", {60'd0, o_busy}, 64'd1);
    chk("t1_nostb", {63'd0, o_tx_stb}, 64'd0);
    step();
    chk("t1_stb", {63'd0, o_tx_stb}, 64'd1);
    step();
    chk("t1_freed", {60'd0, o_busy}, 64'd0);
    chk("t1_hold_grant", {60'd0, o_grant}, 64'd1);
    drain("t1_drain", 20);
    tx_idle();
    chk("t1_idle_grant", {60'd0, o_grant}, 64'd0);

    // All four at once: order 0,1,2,3
    do_reset("rst1");
    for (int i = 0; i < NREQ; i++) begin
      i_data[32*i +: 32] = 32'(i);
      push(4'(1 << i), 32'(i));
    end
    i_stb = 4'b1111;
    step();
    i_stb = '0;
    drain("t2_drain", 100);
    tx_idle();

    // Prime last_grant=1, then 0,2,3 pending with 2 reloading: 2,3,0,2
    do_reset("rst2");
    i_data[63:32] = 32'h1111_0001;
    i_stb         = 4'b0010;
    push(4'b0010, 32'h1111_0001);
    step();
    i_stb = '0;
    drain("t3_prime", 20);
    tx_idle();
    i_data[31:0]   = 32'h0000_0AAA;
    i_data[95:64]  = 32'h2222_0001;
    i_data[127:96] = 32'h3333_0001;
    push(4'b0100, 32'h2222_0001);
    push(4'b1000, 32'h3333_0001);
    push(4'b0001, 32'h0000_0AAA);
    push(4'b0100, RL_WORD);
    rl_arm = 1'b1;
    i_stb  = 4'b1101;
    step();
    i_stb = '0;
    drain("t3_drain", 200);
    tx_idle();

    // Overrun: second strobe on a full slot is dropped
    do_reset("rst3");
    tx_force = 1'b1;
    tx_busy  = 1'b1;
    i_data[63:32] = 32'hAAAA_0001;
    i_stb         = 4'b0010;
    step();
    i_data[63:32] = 32'h1234_5678;
    step();
    i_stb = '0;
    step();
    chk("t4_busy", {60'd0, o_busy}, 64'd2);
    chk("t4_held", {63'd0, o_tx_stb}, 64'd0);
`ifdef TXARB_OVERRUN_EN
    chk("t4_ovr", {60'd0, o_overrun}, 64'd2);
`endif
    tx_force = 1'b0;
    push(4'b0010, 32'hAAAA_0001);
    drain("t4_drain", 20);
    tx_idle();
`ifdef TXARB_OVERRUN_EN
    chk("t4_ovr_sticky", {60'd0, o_overrun}, 64'd2);
`endif

    // Reset during WAIT with slots 1 and 3 full
    do_reset("rst4");
    i_data[63:32]  = 32'h5151_0001;
    i_data[127:96] = 32'h5353_0001;
    push(4'b0010, 32'h5151_0001);
    i_stb = 4'b1010;
    step();
    i_stb = '0;
    drain("t5_first", 20);
    step();
    i_data[63:32] = 32'h5151_0002;
    i_stb         = 4'b0010;
    step();
    i_stb = '0;
    chk("t5_full", {60'd0, o_busy}, 64'd10);
    chk("t5_grant", {60'd0, o_grant}, 64'd2);
    chk("t5_txbusy", {63'd0, tx_busy}, 64'd1);
    do_reset("rst5");
    for (int i = 0; i < 4; i++) step();
    chk("t5_quiet", {60'd0, o_busy}, 64'd0);
    chk("t5_still_busy", {63'd0, tx_busy}, 64'd1);
    i_data[31:0] = 32'h0BAD_F00D;
    i_stb        = 4'b0001;
    push(4'b0001, 32'h0BAD_F00D);
    step();
    i_stb = '0;
    drain("t5_drain", 40);
    tx_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
